rs_issue_select: RTL and testbench
==================================

Name: rs_issue_select

Overview:
- Issue stage directly downstream of the reservation station.
- Each cycle it scans the RS valid vector and selects up to `N` ready entries, subject to per-FU budgets.
- Returns the selected bit vector (`rs_data_issuing`) to the RS so those entries are freed.
- Registers the selected packets into the issue/execute pipeline register, with branch-mask squash/clear and downstream stall handling.

Parameters:
- `N`, `` `N ``: superscalar width; max packets issued per cycle.
- `RS_SZ`, `` `RS_SZ ``: number of RS entries scanned.
- `NUM_ALU`, 3: max ALU-class issues per cycle (`NUM_ALU` ≤ `N`).
- `MULT_LAT`, 4: cycles the single iterative multiplier stays occupied per op (≥ 1).

Ports:
- `clock`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `rs_valid_issue`  in  `RS_SZ`  RS entry holds a ready, not-yet-issued instruction
- `rs_data_next`  in  `RS_PACKET[RS_SZ]`  RS entry contents; uses fields `fu_type` and `b_mask`
- `b_mm_resolve`  in  `B_MASK_MASK`  branch bit being resolved this cycle
- `b_mm_mispred`  in  1  resolved branch mispredicted
- `ex_stall`  in  1  execute stage cannot accept new packets
- `rs_data_issuing`  out  `RS_SZ`  entries issued this cycle (combinational)
- `issue_packets`  out  `RS_PACKET[N]`  issue register contents
- `issue_valid`  out  `N`  slot valid

Behaviour:
Reset (async, on `reset`=1):
- `issue_valid`=0.
- `issue_packets`=0.
- `rr_ptr`=0.
- `mult_cnt`=0.
- `rs_data_issuing` forced 0 while `reset` is high.

Selection (combinational, same cycle):
- Scan indices `rr_ptr`, `rr_ptr`+1, … mod `RS_SZ`.
- Take an entry if `rs_valid_issue[i]`=1 and budget remains:
  - total ≤ `N`
  - ALU ≤ `NUM_ALU`
  - MULT ≤ 1, and only if `mult_cnt`=0
  - LOAD+STORE ≤ 1
  - BRANCH ≤ 1
- Entries failing their budget are skipped; later entries remain eligible.
- Entry squashed (not taken, not reported) if `b_mm_mispred`=1 and (`b_mask` & `b_mm_resolve`)≠0.
- `ex_stall`=1 → nothing selected, `rs_data_issuing`=0.

Issue register (posedge `clock`):
- `ex_stall`=0: load selected packets in scan order into slots 0..k-1; `issue_valid` = k ones (LSB-packed); remaining slots invalid.
- On load, if `b_mm_mispred`=0, clear `b_mm_resolve` bit from each loaded `b_mask`.
- `ex_stall`=1: hold contents, except:
  - mispred squash: clear `issue_valid` of held slots whose `b_mask` hits `b_mm_resolve`;
  - correct resolve: clear the bit in held `b_mask`s.
- Latency: select at cycle t → visible on `issue_packets` at t+1.

Round-robin pointer:
- If k>0: `rr_ptr` ← (index of last selected entry + 1) mod `RS_SZ`.
- Else unchanged.
- Wrap at `RS_SZ`-1 → 0.

Multiplier occupancy:
- MULT selected: `mult_cnt` ← `MULT_LAT`-1.
- Else if `mult_cnt`>0: decrement.
- `MULT_LAT`=1 → never blocks.
- Mispredict does not reset `mult_cnt` (unit still drains).

Boundaries:
- All RS valid → at most `N` issued.
- No valid → `rs_data_issuing`=0, `issue_valid`=0 next cycle (unless stalled).
- Reset mid-stall clears everything.

Optional Feature:
`ISSUE_PERF_CNT_EN`
- Defined: adds outputs `perf_issued` (32b, += k per cycle) and `perf_idle_cycles` (32b, +1 when k=0 and ¬`ex_stall`). Both async-reset to 0; saturate at max.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package:
  - `FU_TYPE` enum (ALU, MULT, LOAD, STORE, BRANCH)
  - `RS_PACKET`, `B_MASK_MASK`
  - `` `N ``, `` `RS_SZ ``, `NUM_SCALAR_BITS`
- Sub-module `rr_budget_picker`: rotating scan with per-class budgets → `rs_data_issuing` + ordered index list. Parent holds `rr_ptr`, `mult_cnt`, issue register, squash logic.

Test Plan:
- N=3, RS entries 0,1,2,5 valid ALU, `rr_ptr`=0 → `rs_data_issuing`=0b0111; next cycle `issue_valid`=0b111 holding 0,1,2; `rr_ptr`=3.
- Entries 1,2 MULT, 3 ALU, `MULT_LAT`=4 → cycle t issues 1,3; entry 2 blocked for cycles t+1..t+3; issues at t+4.
- Entries 6,7,0 valid ALU, `RS_SZ`=8, `rr_ptr`=6 → issue 6,7,0 in slots 0,1,2; `rr_ptr`=1.
- Held slot with `b_mask`=0b0010, `ex_stall`=1, `b_mm_resolve`=0b0010, `b_mm_mispred`=1 → that slot's `issue_valid` clears next cycle; `mispred`=0 variant → slot kept, `b_mask`=0.
- `ex_stall`=1 with valid entries → `rs_data_issuing`=0, register held, `rr_ptr` unchanged.
- Assert `reset` asynchronously mid-cycle with `mult_cnt`=2 → all outputs 0 immediately; after release a MULT issues on the first cycle.

Source files
------------

// File: rtl/rs_issue_select_pkg.sv
// rs_issue_select_pkg: shared sizes, FU classes and RS packet layout for the issue-select stage
package rs_issue_select_pkg;
  localparam int N = 3;
  localparam int RS_SZ = 8;
  localparam int B_MASK_W = 4;
  localparam int TAG_W = 8;
  localparam int NUM_SCALAR_BITS = $clog2(N + 1);
  localparam int IDX_W = RS_SZ > 1 ? $clog2(RS_SZ) : 1;
  localparam int SLOT_W = N > 1 ? $clog2(N) : 1;
  typedef enum logic [2:0] {FU_ALU, FU_MULT, FU_LOAD, FU_STORE, FU_BRANCH} fu_type_e;
  typedef logic [B_MASK_W-1:0] b_mask_t;
  typedef struct packed {
    fu_type_e fu_type;
    b_mask_t b_mask;
    logic [TAG_W-1:0] tag;
  } rs_packet_t;
endpackage

// File: rtl/rs_issue_select_rr_budget_picker.sv
// rr_budget_picker: rotating scan of eligible RS entries under per-FU-class issue budgets
module rr_budget_picker
  import rs_issue_select_pkg::*;
#(
  parameter int NUM_ALU = 3
) (
  input  logic [RS_SZ-1:0] valid,
  input  fu_type_e fu [RS_SZ],
  input  logic [IDX_W-1:0] rr_ptr,
  input  logic mult_free,
  output logic [RS_SZ-1:0] issuing,
  output logic [N-1:0][IDX_W-1:0] order,
  output logic [NUM_SCALAR_BITS-1:0] count,
  output logic [IDX_W-1:0] last,
  output logic mult_taken
);
  int tot, alu, mem, br, p;
  logic take;
  logic [IDX_W-1:0] pi;
  always_comb begin
    issuing = '0;
    order = '0;
    last = rr_ptr;
    mult_taken = 1'b0;
    tot = 0;
    alu = 0;
    mem = 0;
    br = 0;
    p = 0;
    pi = '0;
    take = 1'b0;
    for (int j = 0; j < RS_SZ; j++) begin
      p = int'(rr_ptr) + j;
      pi = IDX_W'(p >= RS_SZ ? p - RS_SZ : p);
      take = valid[pi] && tot < N &&
             (fu[pi] == FU_ALU    ? alu < NUM_ALU :
              fu[pi] == FU_MULT   ? mult_free && !mult_taken :
              fu[pi] == FU_BRANCH ? br == 0 : mem == 0);
      if (take) begin
        issuing[pi] = 1'b1;
        order[SLOT_W'(tot)] = pi;
        last = pi;
        tot = tot + 1;
        if (fu[pi] == FU_ALU) alu = alu + 1;
        if (fu[pi] == FU_MULT) mult_taken = 1'b1;
        if (fu[pi] == FU_BRANCH) br = br + 1;
        if (fu[pi] == FU_LOAD || fu[pi] == FU_STORE) mem = mem + 1;
      end
    end
    count = NUM_SCALAR_BITS'(tot);
  end
endmodule

// File: rtl/rs_issue_select.sv
// rs_issue_select: picks up to N ready RS entries per cycle and registers them for execute.
// Optional ISSUE_PERF_CNT_EN adds saturating issued/idle-cycle counters.
module rs_issue_select
  import rs_issue_select_pkg::*;
#(
  parameter int NUM_ALU = 3,
  parameter int MULT_LAT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic [RS_SZ-1:0] rs_valid_issue,
  input  rs_packet_t [RS_SZ-1:0] rs_data_next,
  input  b_mask_t b_mm_resolve,
  input  logic b_mm_mispred,
  input  logic ex_stall,
  output logic [RS_SZ-1:0] rs_data_issuing,
  output rs_packet_t [N-1:0] issue_packets,
  output logic [N-1:0] issue_valid
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0] perf_issued,
  output logic [31:0] perf_idle_cycles
`endif
);
  localparam int MC_W = MULT_LAT > 1 ? $clog2(MULT_LAT) : 1;
  logic [IDX_W-1:0] rr_ptr, last;
  logic [MC_W-1:0] mult_cnt;
  logic [RS_SZ-1:0] eligible;
  fu_type_e fu [RS_SZ];
  logic [N-1:0][IDX_W-1:0] order;
  logic [NUM_SCALAR_BITS-1:0] count;
  logic mult_taken;
  rs_packet_t [N-1:0] load_pkt, hold_pkt;
  logic [N-1:0] load_valid, hold_valid;
  // squashed entries are invisible to the picker, so they neither issue nor consume budget
  always_comb begin
    for (int i = 0; i < RS_SZ; i++) begin
      eligible[i] = rs_valid_issue[i] && !(b_mm_mispred && |(rs_data_next[i].b_mask & b_mm_resolve)) &&
                    !ex_stall && !reset;
      fu[i] = rs_data_next[i].fu_type;
    end
  end
  rr_budget_picker #(.NUM_ALU(NUM_ALU)) u_picker (
    .valid(eligible),
    .fu(fu),
    .rr_ptr(rr_ptr),
    .mult_free(mult_cnt == '0),
    .issuing(rs_data_issuing),
    .order(order),
    .count(count),
    .last(last),
    .mult_taken(mult_taken)
  );
  always_comb begin
    for (int s = 0; s < N; s++) begin
      load_valid[s] = NUM_SCALAR_BITS'(s) < count;
      load_pkt[s] = load_valid[s] ? rs_data_next[order[s]] : '0;
      if (!b_mm_mispred) load_pkt[s].b_mask = load_pkt[s].b_mask & ~b_mm_resolve;
      hold_valid[s] = issue_valid[s] && !(b_mm_mispred && |(issue_packets[s].b_mask & b_mm_resolve));
      hold_pkt[s] = issue_packets[s];
      if (!b_mm_mispred) hold_pkt[s].b_mask = hold_pkt[s].b_mask & ~b_mm_resolve;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      issue_valid <= '0;
      issue_packets <= '0;
      rr_ptr <= '0;
      mult_cnt <= '0;
    end else begin
      issue_valid <= ex_stall ? hold_valid : load_valid;
      issue_packets <= ex_stall ? hold_pkt : load_pkt;
      if (count != '0) rr_ptr <= last == IDX_W'(RS_SZ - 1) ? '0 : last + IDX_W'(1);
      mult_cnt <= mult_taken ? MC_W'(MULT_LAT - 1) : mult_cnt - MC_W'(mult_cnt != '0);
    end
  end
`ifdef ISSUE_PERF_CNT_EN
  logic [32:0] issued_sum;
  assign issued_sum = {1'b0, perf_issued} + 33'(count);
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_issued <= '0;
      perf_idle_cycles <= '0;
    end else begin
      perf_issued <= issued_sum[32] ? '1 : issued_sum[31:0];
      if (count == '0 && !ex_stall && perf_idle_cycles != '1) perf_idle_cycles <= perf_idle_cycles + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_rs_issue_select.sv
// tb_rs_issue_select: directed checks of selection order, budgets, squash, stall and reset
module tb_rs_issue_select;
  import rs_issue_select_pkg::*;
  logic clock, reset, b_mm_mispred, ex_stall;
  logic [RS_SZ-1:0] rs_valid_issue, rs_data_issuing;
  rs_packet_t [RS_SZ-1:0] rs_data_next;
  rs_packet_t [N-1:0] issue_packets;
  logic [N-1:0] issue_valid;
  b_mask_t b_mm_resolve;
  int n_chk = 0, n_fail = 0;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] perf_issued, perf_idle_cycles;
`endif
  rs_issue_select dut (
    .clock(clock),
    .reset(reset),
    .rs_valid_issue(rs_valid_issue),
    .rs_data_next(rs_data_next),
    .b_mm_resolve(b_mm_resolve),
    .b_mm_mispred(b_mm_mispred),
    .ex_stall(ex_stall),
    .rs_data_issuing(rs_data_issuing),
    .issue_packets(issue_packets),
    .issue_valid(issue_valid)
`ifdef ISSUE_PERF_CNT_EN
    ,
    .perf_issued(perf_issued),
    .perf_idle_cycles(perf_idle_cycles)
`endif
  );
  initial clock = 1'b0;
  always #5 clock = ~clock;
  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask
  task automatic set(input int i, input fu_type_e f, input b_mask_t m);
    rs_data_next[i[IDX_W-1:0]] = '{fu_type: f, b_mask: m, tag: TAG_W'(i)};
  endtask
  task automatic tick;
    @(posedge clock);
    #1;
  endtask
  function automatic logic [31:0] tags3();
    return {8'h0, issue_packets[2].tag, issue_packets[1].tag, issue_packets[0].tag};
  endfunction
  initial begin
    reset = 1'b1;
    ex_stall = 1'b0;
    b_mm_mispred = 1'b0;
    b_mm_resolve = '0;
    for (int i = 0; i < RS_SZ; i++) set(i, FU_ALU, '0);
    rs_valid_issue = '1;
    #2;
    chk("rst_issuing", 32'(rs_data_issuing), 32'h0);
    chk("rst_valid", 32'(issue_valid), 32'h0);
    chk("rst_pkt", 32'(issue_packets[0]), 32'h0);
    tick;
    tick;
    reset = 1'b0;
    rs_valid_issue = 8'b0010_0111;
    #1 chk("first_iss", 32'(rs_data_issuing), 32'h07);
    tick;
    chk("first_valid", 32'(issue_valid), 32'h7);
    chk("first_tags", tags3() & 32'hffffff, 32'h020100);
    rs_valid_issue = 8'b0010_0010;
    #1 chk("rr3_iss", 32'(rs_data_issuing), 32'h22);
    tick;
    chk("rr3_valid", 32'(issue_valid), 32'h3);
    chk("rr3_order", tags3() & 32'hffff, 32'h0105);
    rs_valid_issue = 8'b0010_0000;
    #1 chk("single_iss", 32'(rs_data_issuing), 32'h20);
    tick;
    chk("single_valid", 32'(issue_valid), 32'h1);
    rs_valid_issue = 8'b1100_0001;
    #1 chk("wrap_iss", 32'(rs_data_issuing), 32'hc1);
    tick;
    chk("wrap_valid", 32'(issue_valid), 32'h7);
    chk("wrap_order", tags3(), 32'h000706);
    rs_valid_issue = 8'b0000_0011;
    #1 chk("rr1_iss", 32'(rs_data_issuing), 32'h03);
    tick;
    chk("rr1_order", tags3() & 32'hffff, 32'h0001);
    rs_valid_issue = '0;
    #1 chk("idle_iss", 32'(rs_data_issuing), 32'h0);
    tick;
    chk("idle_valid", 32'(issue_valid), 32'h0);
    set(1, FU_MULT, '0);
    set(2, FU_MULT, '0);
    set(3, FU_ALU, '0);
    rs_valid_issue = 8'b0000_1110;
    #1 chk("mult_iss", 32'(rs_data_issuing), 32'h0a);
    tick;
    chk("mult_valid", 32'(issue_valid), 32'h3);
    chk("mult_order", tags3() & 32'hffff, 32'h0301);
    rs_valid_issue = 8'b0000_0100;
    for (int c = 0; c < 3; c++) begin
      #1 chk("mult_busy_iss", 32'(rs_data_issuing), 32'h0);
      tick;
      chk("mult_busy_valid", 32'(issue_valid), 32'h0);
    end
    #1 chk("mult_free_iss", 32'(rs_data_issuing), 32'h04);
    tick;
    chk("mult_free_tag", 32'(issue_packets[0].tag), 32'h2);
    set(3, FU_LOAD, '0);
    set(4, FU_STORE, '0);
    set(5, FU_BRANCH, '0);
    set(6, FU_BRANCH, '0);
    set(7, FU_ALU, '0);
    rs_valid_issue = 8'b1111_1000;
    #1 chk("budget_iss", 32'(rs_data_issuing), 32'ha8);
    tick;
    chk("budget_order", tags3(), 32'h070503);
    for (int i = 0; i < RS_SZ; i++) set(i, FU_ALU, '0);
    ex_stall = 1'b1;
    rs_valid_issue = 8'b0000_0011;
    #1 chk("stall_iss", 32'(rs_data_issuing), 32'h0);
    tick;
    chk("stall_valid", 32'(issue_valid), 32'h7);
    chk("stall_hold", tags3(), 32'h070503);
    ex_stall = 1'b0;
    set(0, FU_ALU, 4'b0010);
    set(1, FU_ALU, 4'b0100);
    rs_valid_issue = 8'b0000_0111;
    #1 chk("post_stall_iss", 32'(rs_data_issuing), 32'h07);
    tick;
    chk("post_stall_order", tags3(), 32'h020100);
    ex_stall = 1'b1;
    rs_valid_issue = '0;
    b_mm_resolve = 4'b0010;
    b_mm_mispred = 1'b1;
    tick;
    chk("held_squash", 32'(issue_valid), 32'h6);
    b_mm_resolve = 4'b0100;
    b_mm_mispred = 1'b0;
    tick;
    chk("held_resolve_valid", 32'(issue_valid), 32'h6);
    chk("held_resolve_mask", 32'(issue_packets[1].b_mask), 32'h0);
    ex_stall = 1'b0;
    b_mm_resolve = 4'b0001;
    b_mm_mispred = 1'b1;
    set(3, FU_ALU, 4'b0001);
    rs_valid_issue = 8'b0001_1000;
    #1 chk("rs_squash_iss", 32'(rs_data_issuing), 32'h10);
    tick;
    chk("rs_squash_valid", 32'(issue_valid), 32'h1);
    chk("rs_squash_tag", 32'(issue_packets[0].tag), 32'h4);
    b_mm_resolve = 4'b0010;
    b_mm_mispred = 1'b0;
    set(5, FU_ALU, 4'b0011);
    rs_valid_issue = 8'b0010_0000;
    #1 chk("load_clear_iss", 32'(rs_data_issuing), 32'h20);
    tick;
    chk("load_clear_mask", 32'(issue_packets[0].b_mask), 32'h1);
    b_mm_resolve = '0;
    set(5, FU_ALU, '0);
    rs_valid_issue = '1;
    #1 chk("all_valid_iss", 32'(rs_data_issuing), 32'hc1);
    tick;
    chk("all_valid_valid", 32'(issue_valid), 32'h7);
    set(1, FU_MULT, '0);
    rs_valid_issue = 8'b0000_0010;
    #1 chk("pre_rst_mult", 32'(rs_data_issuing), 32'h02);
    tick;
    rs_valid_issue = 8'b0000_0001;
    #1 chk("pre_rst_alu", 32'(rs_data_issuing), 32'h01);
    tick;
    chk("pre_rst_valid", 32'(issue_valid), 32'h1);
    ex_stall = 1'b1;
    rs_valid_issue = 8'b0000_0010;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_valid", 32'(issue_valid), 32'h0);
    chk("async_rst_pkt", 32'(issue_packets[0]), 32'h0);
    chk("async_rst_iss", 32'(rs_data_issuing), 32'h0);
    #1 reset = 1'b0;
    ex_stall = 1'b0;
    #1 chk("post_rst_mult_iss", 32'(rs_data_issuing), 32'h02);
    tick;
    chk("post_rst_mult_valid", 32'(issue_valid), 32'h1);
    chk("post_rst_mult_tag", 32'(issue_packets[0].tag), 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
